// File: rtl/sha256_msg_padder.sv
// SHA-256 front end: packs message bytes into 512-bit blocks, appends 0x80 / zero fill / 64-bit length,
// and streams each block as 16 words; msg_ready drops while padding, sending or waiting on core_busy.
module sha256_msg_padder #(
  parameter int LEN_W   = 32,
  parameter int GAP_MIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        msg_valid,
  input  logic [7:0]  msg_byte,
  input  logic        msg_last,
  output logic        msg_ready,
  input  logic        core_busy,
  output logic [31:0] data,
  output logic        write_enable,
  output logic        first_block,
  output logic        last_block,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_SEND_PRE, S_SEND, S_WAIT, S_DONE
  } state_t;

  localparam int GW = (GAP_MIN < 1) ? 1 : $clog2(GAP_MIN + 1);

  state_t           state_q, state_d;
  logic [63:0][7:0] buf_q, buf_d;
  logic [5:0]       pos_q, pos_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       word_q, word_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             first_q, first_d;
  logic             final_q, final_d;
  logic             cont_q, cont_d;   // next block continues in PAD (length-only or marker-first)
  logic             mark_q, mark_d;   // 0x80 marker still to be written
  logic [63:0]      bit_len;
  logic [31:0]      word_sel;

  assign bit_len  = 64'({cnt_q, 3'b000});
  assign word_sel = {buf_q[{word_q, 2'd0}], buf_q[{word_q, 2'd1}],
                     buf_q[{word_q, 2'd2}], buf_q[{word_q, 2'd3}]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
      first_q <= 1'b0;
      final_q <= 1'b0;
      cont_q  <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
      first_q <= first_d;
      final_q <= final_d;
      cont_q  <= cont_d;
      mark_q  <= mark_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    gap_d   = gap_q;
    first_d = first_q;
    final_d = final_q;
    cont_d  = cont_q;
    mark_d  = mark_q;
    case (state_q)
      S_IDLE, S_FILL: begin
        if (msg_valid) begin
          buf_d[pos_q] = msg_byte;
          cnt_d        = cnt_q + LEN_W'(1);
          if (state_q == S_IDLE) begin
            first_d = 1'b1;
            final_d = 1'b0;
            cont_d  = 1'b0;
          end
          // A final byte that fills the block: send it, then pad into a fresh block
          if (msg_last && pos_q == 6'd63) begin
            state_d = S_SEND_PRE;
            pos_d   = '0;
            cont_d  = 1'b1;
            mark_d  = 1'b1;
          end else if (msg_last) begin
            state_d = S_PAD;
            pos_d   = pos_q + 6'd1;
            mark_d  = 1'b1;
          end else if (pos_q == 6'd63) begin
            state_d = S_SEND_PRE;
            pos_d   = '0;
            cont_d  = 1'b0;
          end else begin
            state_d = S_FILL;
            pos_d   = pos_q + 6'd1;
          end
        end
      end
      S_PAD: begin
        buf_d[pos_q] = mark_q ? 8'h80 : 8'h00;
        mark_d       = 1'b0;
        if (pos_q == 6'd55) begin
          for (int k = 0; k < 8; k++) begin
            buf_d[56+k] = bit_len[63-8*k -: 8];
          end
          final_d = 1'b1;
          cont_d  = 1'b0;
          pos_d   = '0;
          state_d = S_SEND_PRE;
        end else if (pos_q == 6'd63) begin
          cont_d  = 1'b1;
          pos_d   = '0;
          state_d = S_SEND_PRE;
        end else begin
          pos_d = pos_q + 6'd1;
        end
      end
      S_SEND_PRE: begin
        word_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        word_d = word_q + 4'd1;
        if (word_q == 4'd15) begin
          first_d = 1'b0;
          gap_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Hold off sampling busy until the core has had time to raise it
        if (gap_q < GW'(GAP_MIN)) begin
          gap_d = gap_q + GW'(1);
        end else if (!core_busy) begin
          if (final_q)     state_d = S_DONE;
          else if (cont_q) state_d = S_PAD;
          else             state_d = S_FILL;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        final_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msg_ready    = reset && (state_q == S_IDLE || state_q == S_FILL);
    write_enable = (state_q == S_SEND);
    data         = write_enable ? word_sel : 32'h0;
    first_block  = first_q && (state_q == S_SEND_PRE || (state_q == S_SEND && word_q == 4'd0));
    last_block   = final_q && state_q == S_SEND && word_q == 4'd0;
    done         = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: vector table of messages with hand-computed padded blocks.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        msg_valid = 1'b0;
  logic [7:0]  msg_byte = 8'h00;
  logic        msg_last = 1'b0;
  logic        msg_ready;
  logic        core_busy = 1'b0;
  logic [31:0] data;
  logic        write_enable;
  logic        first_block;
  logic        last_block;
  logic        done;

  sha256_msg_padder dut (
    .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_byte(msg_byte),
    .msg_last(msg_last), .msg_ready(msg_ready), .core_busy(core_busy),
    .data(data), .write_enable(write_enable), .first_block(first_block),
    .last_block(last_block), .done(done)
  );

  always #5 clk = ~clk;

  // Message length/pattern, expected block count, value of every fully-filled data word,
  // and two explicitly hand-computed words (marker / length positions) across the block stream.
  typedef struct packed {
    int          len;
    logic [7:0]  b0;
    logic        inc;
    int          nblk;
    logic [31:0] fw;
    int          si0;
    logic [31:0] sv0;
    int          si1;
    logic [31:0] sv1;
  } vec_t;

  vec_t vt [7];
  vec_t vbusy;
  vec_t vabc;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] wq [$];
  logic        fq [$];
  logic        lq [$];
  int done_cnt = 0;
  int pre_first = 0;
  int zero_viol = 0;
  int w_base, d_base, pf_base, zv_base;

  always @(negedge clk) begin
    if (reset) begin
      if (write_enable) begin
        wq.push_back(data);
        fq.push_back(first_block);
        lq.push_back(last_block);
      end else begin
        if (data != 32'h0) zero_viol++;
        if (last_block) zero_viol++;
        if (first_block) pre_first++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    w_base  = wq.size();
    d_base  = done_cnt;
    pf_base = pre_first;
    zv_base = zero_viol;
  endtask

  task automatic send_msg(input int len, input logic [7:0] b0, input logic inc);
    for (int i = 0; i < len; i++) begin
      int   guard;
      logic acc;
      msg_valid = 1'b1;
      msg_byte  = inc ? b0 + 8'(i) : b0;
      msg_last  = (i == len - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        acc = msg_ready;
        step();
        guard++;
        if (!acc && guard > 2000) begin
          chk("byte_accept_timeout", 32'(i), 32'(len));
          msg_valid = 1'b0;
          msg_last  = 1'b0;
          return;
        end
      end
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    msg_byte  = 8'h00;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt < d_base + 1 && g < 3000) begin
      step();
      g++;
    end
    repeat (3) step();
  endtask

  task automatic check_vec(input vec_t v, input string nm);
    int nw = 16 * v.nblk;
    chk({nm, "_nwords"}, 32'(wq.size() - w_base), 32'(nw));
    for (int idx = 0; idx < nw; idx++) begin
      if (w_base + idx < wq.size()) begin
        logic [31:0] e;
        e = (idx * 4 + 3 < v.len) ? v.fw : 32'h0;
        if (idx == v.si0) e = v.sv0;
        if (idx == v.si1) e = v.sv1;
        chk($sformatf("%s_w%0d", nm, idx), wq[w_base+idx], e);
        chk($sformatf("%s_first%0d", nm, idx), 32'(fq[w_base+idx]), 32'(idx == 0));
        chk($sformatf("%s_last%0d", nm, idx), 32'(lq[w_base+idx]), 32'(idx == nw - 16));
      end
    end
    chk({nm, "_done_pulses"}, 32'(done_cnt - d_base), 32'd1);
    chk({nm, "_pre_first"}, 32'(pre_first - pf_base), 32'd1);
    chk({nm, "_idle_outputs"}, 32'(zero_viol - zv_base), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    snapshot();
    send_msg(v.len, v.b0, v.inc);
    wait_done();
    check_vec(v, nm);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_data"}, data, 32'h0);
    chk({nm, "_we"}, 32'(write_enable), 32'd0);
    chk({nm, "_first"}, 32'(first_block), 32'd0);
    chk({nm, "_last"}, 32'(last_block), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_ready"}, 32'(msg_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t required below 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int rdy_hi;

    vt[0] = '{3,  8'h61, 1'b1, 1, 32'h0,        0,  32'h61626380, 15, 32'h00000018};
    vt[1] = '{56, 8'h30, 1'b0, 2, 32'h30303030, 14, 32'h80000000, 31, 32'h000001C0};
    vt[2] = '{55, 8'h30, 1'b0, 1, 32'h30303030, 13, 32'h30303080, 15, 32'h000001B8};
    vt[3] = '{64, 8'h30, 1'b0, 2, 32'h30303030, 16, 32'h80000000, 31, 32'h00000200};
    vt[4] = '{1,  8'hAB, 1'b0, 1, 32'h0,        0,  32'hAB800000, 15, 32'h00000008};
    vt[5] = '{60, 8'h30, 1'b0, 2, 32'h30303030, 15, 32'h80000000, 31, 32'h000001E0};
    vt[6] = '{63, 8'h30, 1'b0, 2, 32'h30303030, 15, 32'h30303080, 31, 32'h000001F8};
    vbusy = '{67, 8'h30, 1'b0, 2, 32'h30303030, 16, 32'h30303080, 31, 32'h00000218};
    vabc  = vt[0];

    #3 reset = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    for (int t = 0; t < 7; t++) begin
      run_vec(vt[t], $sformatf("vec%0d", t));
    end

    // Busy held after block 1 while the source keeps offering the next byte
    snapshot();
    fork
      send_msg(vbusy.len, vbusy.b0, vbusy.inc);
      begin
        g = 0;
        while (wq.size() < w_base + 16 && g < 2000) begin
          step();
          g++;
        end
        core_busy = 1'b1;
        rdy_hi = 0;
        repeat (40) begin
          step();
          if (msg_ready) rdy_hi++;
        end
        chk("busy_ready_held_low", 32'(rdy_hi), 32'd0);
        core_busy = 1'b0;
        chk("busy_ready_before_resume", 32'(msg_ready), 32'd0);
        step();
        chk("busy_ready_after_fall", 32'(msg_ready), 32'd1);
      end
    join
    wait_done();
    check_vec(vbusy, "busy67");

    // Reset during word 7 of a block, then a clean message
    send_msg(3, 8'h61, 1'b1);
    g = 0;
    while (!write_enable && g < 500) begin
      step();
      g++;
    end
    repeat (7) step();
    chk("midrst_we_before", 32'(write_enable), 32'd1);
    reset = 1'b0;
    #1 chk_outputs_zero("midrst");
    step();
    step();
    reset = 1'b1;
    step();
    run_vec(vabc, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
